// File: rtl/deserializer_if.sv
// Parallel-side port of the deserializer: received word, valid/ready handshake and status pulses.
// parity_error exists only when DESERIALIZER_PARITY_EN is defined.
interface deserializer_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid;
  logic                  ready;
  logic                  busy;
  logic                  framing_error;
  logic                  overrun;
`ifdef DESERIALIZER_PARITY_EN
  logic                  parity_error;
`endif

  modport master (
    output data_out, valid, busy, framing_error, overrun,
`ifdef DESERIALIZER_PARITY_EN
    output parity_error,
`endif
    input  ready
  );

  modport slave (
    input  data_out, valid, busy, framing_error, overrun,
`ifdef DESERIALIZER_PARITY_EN
    input  parity_error,
`endif
    output ready
  );
endinterface

// File: rtl/deserializer.sv
// Idle-high, LSB-first serial receiver with start/stop framing and a one-entry output buffer.
// Optional even-parity bit enabled by defining DESERIALIZER_PARITY_EN.
module deserializer #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic           serial_in,
  deserializer_if.master bus
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT) + 1;
  localparam int unsigned BitW = $clog2(DATA_WIDTH + 1);
  localparam int unsigned Half = CLKS_PER_BIT / 2;
  localparam logic [CntW-1:0] BitLoad  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfLoad = CntW'((Half == 0) ? 0 : Half - 1);
  localparam logic [BitW-1:0] LastBit  = BitW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef DESERIALIZER_PARITY_EN
    StParity,
`endif
    StStop,
    StWaitHigh
  } state_e;

  state_e                state_q, state_d;
  logic [1:0]            sync_q;
  logic                  s;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [BitW-1:0]       bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q;
  logic                  frame_err_q, frame_err_d;
  logic                  overrun_q;
  logic                  deliver;
  logic                  tick;
`ifdef DESERIALIZER_PARITY_EN
  logic                  par_q, par_d;
  logic                  par_err_q, par_err_d;
`endif

  assign s    = sync_q[1];
  assign tick = (cnt_q == '0);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    deliver     = 1'b0;
    frame_err_d = 1'b0;
`ifdef DESERIALIZER_PARITY_EN
    par_d       = par_q;
    par_err_d   = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (!s) begin
          bit_d = '0;
          // With one clock per bit the detection cycle already is the start-bit sample.
          if (Half == 0) begin
            state_d = StData;
            cnt_d   = BitLoad;
          end else begin
            state_d = StStart;
            cnt_d   = HalfLoad;
          end
        end
      end
      StStart: begin
        if (tick) begin
          state_d = s ? StIdle : StData;
          cnt_d   = BitLoad;
          bit_d   = '0;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StData: begin
        if (tick) begin
          // Shifting in from the top leaves bit k at position k after the last sample.
          shift_d = {s, shift_q[DATA_WIDTH-1:1]};
          cnt_d   = BitLoad;
          bit_d   = bit_q + BitW'(1);
          if (bit_q == LastBit) begin
`ifdef DESERIALIZER_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
`ifdef DESERIALIZER_PARITY_EN
      StParity: begin
        if (tick) begin
          par_d   = s;
          cnt_d   = BitLoad;
          state_d = StStop;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
`endif
      StStop: begin
        if (tick) begin
          if (s) begin
            deliver = 1'b1;
            state_d = StIdle;
`ifdef DESERIALIZER_PARITY_EN
            par_err_d = (par_q != ^shift_q);
`endif
          end else begin
            frame_err_d = 1'b1;
            state_d     = StWaitHigh;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StWaitHigh: begin
        if (s) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q      <= 2'b11;
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
`ifdef DESERIALIZER_PARITY_EN
      par_q       <= 1'b0;
      par_err_q   <= 1'b0;
`endif
    end else begin
      sync_q      <= {sync_q[0], serial_in};
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
`ifdef DESERIALIZER_PARITY_EN
      par_q       <= par_d;
      par_err_q   <= par_err_d;
`endif
    end
  end

  // One-entry buffer: a same-cycle accept frees the slot for the incoming word.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= deliver && valid_q && !bus.ready;
      if (deliver && (!valid_q || bus.ready)) begin
        data_q  <= shift_q;
        valid_q <= 1'b1;
      end else if (!deliver && valid_q && bus.ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.data_out      = data_q;
  assign bus.valid         = valid_q;
  assign bus.busy          = (state_q != StIdle);
  assign bus.framing_error = frame_err_q;
  assign bus.overrun       = overrun_q;
`ifdef DESERIALIZER_PARITY_EN
  assign bus.parity_error  = par_err_q;
`endif

endmodule

// File: tb/tb_deserializer.sv
// Scoreboard bench for deserializer at DATA_WIDTH=8, CLKS_PER_BIT=4.
// Parity case is compiled in when DESERIALIZER_PARITY_EN is defined.
module tb_deserializer;
  localparam int unsigned DW  = 8;
  localparam int unsigned CPB = 4;
`ifdef DESERIALIZER_PARITY_EN
  localparam int unsigned PB = 1;
`else
  localparam int unsigned PB = 0;
`endif
  // Edge offset from start-bit drive to the stop-bit sample: 3 sync/detect edges + half bit.
  localparam int unsigned StopOff = 3 + CPB / 2 + (DW + 1 + PB) * CPB;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic serial_in = 1'b1;

  deserializer_if #(.DATA_WIDTH(DW)) bus ();

  deserializer #(
    .DATA_WIDTH  (DW),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .serial_in(serial_in),
    .bus      (bus)
  );

  always #5 clock = ~clock;

  int unsigned total = 0;
  int unsigned bad = 0;
  int unsigned cyc = 0;
  int unsigned ov_cnt = 0;
  int unsigned fe_cnt = 0;
  int unsigned pe_cnt = 0;
  logic [7:0] sb[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: just after each falling edge, ready/valid are what the next rising edge sees.
  always @(negedge clock) begin
    #1;
    if (reset_n) begin
      if (bus.valid && bus.ready) begin
        if (sb.size() == 0) check("accept_with_empty_sb", 32'(sb.size()), 32'd1);
        else check("data", 32'(bus.data_out), 32'(sb.pop_front()));
      end
      if (bus.overrun) ov_cnt++;
      if (bus.framing_error) fe_cnt++;
`ifdef DESERIALIZER_PARITY_EN
      if (bus.parity_error) begin
        pe_cnt++;
        check("perr_with_valid", 32'(bus.valid), 32'd1);
      end
`endif
    end
  end

  task automatic send_bit(input logic b);
    serial_in = b;
    repeat (CPB) @(negedge clock);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_flip);
    send_bit(1'b0);
    for (int i = 0; i < DW; i++) send_bit(d[i]);
`ifdef DESERIALIZER_PARITY_EN
    send_bit((^d) ^ par_flip);
`else
    if (par_flip) serial_in = 1'b1;
`endif
    send_bit(stop);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data"}, 32'(bus.data_out), 32'd0);
    check({tag, "_valid"}, 32'(bus.valid), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_ferr"}, 32'(bus.framing_error), 32'd0);
    check({tag, "_ovr"}, 32'(bus.overrun), 32'd0);
`ifdef DESERIALIZER_PARITY_EN
    check({tag, "_perr"}, 32'(bus.parity_error), 32'd0);
`endif
  endtask

  initial begin
    int unsigned p0;
    bus.ready = 1'b1;
    repeat (3) @(negedge clock);
    check_reset_outputs("reset");
    reset_n = 1'b1;
    repeat (5) @(negedge clock);

    // Good frame: valid for exactly one cycle right after the stop sample.
    sb.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 1'b0);
    @(negedge clock);
    check("good_valid", 32'(bus.valid), 32'd1);
    check("good_data", 32'(bus.data_out), 32'hA5);
    check("good_busy_fall", 32'(bus.busy), 32'd0);
    @(negedge clock);
    check("good_valid_one_cycle", 32'(bus.valid), 32'd0);
    check("good_no_ferr", fe_cnt, 32'd0);
    check("good_no_ovr", ov_cnt, 32'd0);

    // Glitch: one low cycle must be rejected in START.
    serial_in = 1'b0;
    @(negedge clock);
    serial_in = 1'b1;
    repeat (10) @(negedge clock);
    check("glitch_busy", 32'(bus.busy), 32'd0);
    check("glitch_valid", 32'(bus.valid), 32'd0);
    check("glitch_ferr", fe_cnt, 32'd0);

    // Framing error followed by a held-low break.
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (40) @(negedge clock);
    check("fe_count", fe_cnt, 32'd1);
    check("fe_valid", 32'(bus.valid), 32'd0);
    check("fe_busy_waithigh", 32'(bus.busy), 32'd1);
    serial_in = 1'b1;
    repeat (6) @(negedge clock);
    check("fe_busy_released", 32'(bus.busy), 32'd0);
    check("fe_count_after", fe_cnt, 32'd1);

    // Overrun: second word dropped while the first is held.
    bus.ready = 1'b0;
    sb.push_back(8'h11);
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    repeat (5) @(negedge clock);
    check("ovr_count", ov_cnt, 32'd1);
    check("ovr_data_kept", 32'(bus.data_out), 32'h11);
    check("ovr_valid", 32'(bus.valid), 32'd1);
    bus.ready = 1'b1;
    @(negedge clock);
    bus.ready = 1'b0;
    repeat (2) @(negedge clock);
    check("ovr_drained", 32'(bus.valid), 32'd0);

    // Same-cycle accept: ready only in the second delivery cycle.
    sb.push_back(8'h11);
    sb.push_back(8'h22);
    send_frame(8'h11, 1'b1, 1'b0);
    p0 = cyc;
    fork
      send_frame(8'h22, 1'b1, 1'b0);
      begin
        while (cyc < p0 + StopOff - 1) @(negedge clock);
        bus.ready = 1'b1;
        @(negedge clock);
        bus.ready = 1'b0;
      end
    join
    repeat (3) @(negedge clock);
    check("sca_data", 32'(bus.data_out), 32'h22);
    check("sca_valid", 32'(bus.valid), 32'd1);
    check("sca_no_ovr", ov_cnt, 32'd1);
    bus.ready = 1'b1;
    repeat (2) @(negedge clock);

    // Reset in data bit 3; only the next word may appear.
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    serial_in = 1'b1;
    repeat (2) @(negedge clock);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (5) @(negedge clock);
    sb.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, 1'b0);
    @(negedge clock);
    check("after_reset_data", 32'(bus.data_out), 32'h5A);
    repeat (4) @(negedge clock);

`ifdef DESERIALIZER_PARITY_EN
    sb.push_back(8'h07);
    send_frame(8'h07, 1'b1, 1'b1);
    @(negedge clock);
    check("par_data", 32'(bus.data_out), 32'h07);
    check("par_valid", 32'(bus.valid), 32'd1);
    repeat (3) @(negedge clock);
    check("par_count", pe_cnt, 32'd1);
`endif

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/deserializer.md
# deserializer

Serial-to-parallel receive stage for the board's single-wire byte links. Consumes the idle-high, LSB-first serial stream produced by the transmit-side serializer. Frames each word with start/stop detection and presents it on a valid/ready parallel port to the downstream consumer. Reports framing and overrun errors as single-cycle pulses.

## Interface
- `DATA_WIDTH`, default 8: bits per word.
- `CLKS_PER_BIT`, default 1: clock cycles per serial bit; minimum 1.
- `clock`  input  1  rising-edge clock for all state.
- `reset_n`  input  1  asynchronous, active-low reset.
- `serial_in`  input  1  serial line; idles high.
- `data_out`  output  DATA_WIDTH  received word; held stable while `valid` is 1.
- `valid`  output  1  `data_out` holds an unconsumed word.
- `ready`  input  1  consumer accepts the word when `valid && ready`.
- `busy`  output  1  a frame is in progress (FSM not IDLE).
- `framing_error`  output  1  one-cycle pulse on a bad stop bit.
- `overrun`  output  1  one-cycle pulse when a completed word is dropped.
- `parity_error`  output  1  present only with `DESERIALIZER_PARITY_EN`.

## Operation
- Frame format:
  - 1 start bit (0).
  - DATA_WIDTH data bits, LSB first.
  - [parity bit]: even parity, bit = XOR of data bits.
  - 1 stop bit (1).
- Input synchronizer:
  - `serial_in` passes through a 2-flop synchronizer (reset value 1); all decisions use the synchronized line `s`.
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP, WAIT_HIGH.
  - IDLE -> START when `s`=0; the bit-cycle counter is loaded with CLKS_PER_BIT/2 (integer division).
  - START -> DATA when the counter expires and `s`=0 (start bit confirmed).
  - START -> IDLE when the counter expires and `s`=1 (glitch rejected). No outputs change.
  - DATA: samples every CLKS_PER_BIT cycles. Bit k goes into shift register position k. Exits after DATA_WIDTH samples.
  - PARITY (macro only): samples one bit, then -> STOP.
  - STOP, sample = 1: the word is delivered and the FSM -> IDLE.
  - STOP, sample = 0: `framing_error` pulses, the word is discarded, and the FSM -> WAIT_HIGH.
  - WAIT_HIGH -> IDLE once `s`=1, so a held-low (break) line never produces repeated frames.
- Sample point arithmetic:
  - Let t0 = cycle `s` is first seen low in IDLE.
  - Bit index k (start bit = 0) is sampled at t0 + CLKS_PER_BIT/2 + k·CLKS_PER_BIT.
  - Bit counter is $clog2(DATA_WIDTH+1) bits wide; cycle counter is $clog2(CLKS_PER_BIT)+1 bits wide.
- Output buffer (one entry):
  - Delivery when `valid`=0: load `data_out`, set `valid`.
  - Delivery when `valid && ready` in the same cycle: load the new word and keep `valid`=1; no overrun.
  - Delivery when `valid && !ready`: keep the old word and pulse `overrun`.
  - `valid && ready` with no delivery: clear `valid`; `data_out` holds its value.
- Reset:
  - Mid-frame reset aborts the frame. No partial word is ever delivered.

## Timing
- Reset values:
  - `data_out`=0, `valid`=0, `busy`=0, `framing_error`=0, `overrun`=0, `parity_error`=0.
  - FSM = IDLE.
  - Synchronizer flops = 1.
- Latency: a line edge reaches `s` 2 cycles after `serial_in` changes.
- Delivery timing:
  - `valid` rises the cycle after the stop-bit sample.
  - `framing_error` and `parity_error` pulse in that same cycle.
  - `overrun` pulses in the delivery cycle.
- `busy`:
  - Rises the cycle after `s` is seen low in IDLE.
  - Falls the cycle after the stop-bit sample.
  - Stays high through WAIT_HIGH.
- With CLKS_PER_BIT=1, a frame can begin in the cycle after STOP returns the FSM to IDLE, so back-to-back frames are received without gaps.

## Configuration
- `DESERIALIZER_PARITY_EN` defined:
  - The PARITY state and the `parity_error` port exist.
  - A parity mismatch still delivers the word and pulses `parity_error` in the delivery cycle.
  - A parity mismatch combined with a bad stop bit reports only `framing_error`.
- `DESERIALIZER_PARITY_EN` undefined:
  - No PARITY state and no `parity_error` port.
  - Frame length is DATA_WIDTH+2 bits.

## Test plan
- Good frame: DATA_WIDTH=8, CLKS_PER_BIT=4, send 0xA5 with `ready`=1 -> `data_out`=0xA5 and `valid` high for 1 cycle, starting the cycle after the stop sample; no error pulses.
- Glitch rejection: `serial_in` low for 1 cycle, CLKS_PER_BIT=4 -> START returns to IDLE; `valid`, `busy` after the START window, and all errors stay 0.
- Framing error: send 0x3C with stop bit 0, then hold the line low for 40 cycles -> one `framing_error` pulse, `valid`=0, no further frames until the line returns high.
- Overrun and same-cycle accept:
  - Send 0x11 then 0x22 with `ready`=0 -> `data_out`=0x11 and one `overrun` pulse.
  - Repeat with `ready` asserted in the second delivery cycle -> `data_out`=0x22 and no overrun.
- Reset mid-frame: assert `reset_n`=0 during data bit 3, release it, then send 0x5A -> all outputs at reset values during reset, and only 0x5A is delivered afterwards.
- Parity (macro defined): send 0x07 with parity bit 0 -> `data_out`=0x07, `valid`=1, and `parity_error` pulses in the same cycle.
